// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store front-end.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RMW_RD,
    ST_WR,
    ST_WR_WAIT,
    ST_RESP
  } state_e;

  localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: extracts and extends load data, merges sub-word store data.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  offset_i,
  input  logic        signed_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v  = word_i[{offset_i, 3'b000} +: 8];
    half_v  = word_i[{offset_i[1], 4'b0000} +: 16];
    load_o  = word_i;
    merge_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o  = {{24{signed_i & byte_v[7]}}, byte_v};
        merge_o = word_i;
        merge_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        // addr[0] deliberately ignored: half lanes sit on 16-bit boundaries
        load_o  = {{16{signed_i & half_v[15]}}, half_v};
        merge_o = word_i;
        merge_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        load_o  = word_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end to a word-addressed memory; RMW for sub-word stores.
// Optional alignment fault checking: define MEM_ACCESS_UNIT_MISALIGN_CHECK_EN.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_write_done,
  input  logic              mem_available
);

  if (DATA_W != 32) begin : g_data_w_check
    $error("mem_access_unit: DATA_W must be 32");
  end

  state_e      state_q;
  size_e       size_q;
  logic [1:0]  off_q;
  logic        signed_q;
  logic [31:0] wdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        mem_rd_q;
  logic        mem_wr_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  size_e       req_sz;
  logic        fault;
  logic [31:0] load_data;
  logic [31:0] merged_data;

  assign req_sz = size_e'(req_size);

`ifdef MEM_ACCESS_UNIT_MISALIGN_CHECK_EN
  assign fault = ((req_sz == SZ_HALF) && req_addr[0]) ||
                 ((req_sz == SZ_WORD) && (req_addr[1:0] != 2'b00)) ||
                 (req_sz == SZ_RSVD);
`else
  assign fault = 1'b0;
`endif

  mem_lane_align u_align (
    .size_i   (size_q),
    .offset_i (off_q),
    .signed_i (signed_q),
    .word_i   (mem_rdata),
    .wdata_i  (wdata_q),
    .load_o   (load_data),
    .merge_o  (merged_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      size_q       <= SZ_BYTE;
      off_q        <= 2'b00;
      signed_q     <= 1'b0;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (req_valid) begin
          size_q       <= req_sz;
          off_q        <= req_addr[1:0];
          signed_q     <= req_signed;
          wdata_q      <= req_wdata;
          mem_addr_q   <= 32'(req_addr >> WORD_SHIFT);
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
          if (fault) begin
            resp_err_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else if (!req_we) begin
            mem_rd_q <= 1'b1;
            state_q  <= ST_RD;
          end else if (req_sz == SZ_BYTE || req_sz == SZ_HALF) begin
            mem_rd_q <= 1'b1;
            state_q  <= ST_RMW_RD;
          end else begin
            mem_wdata_q <= req_wdata;
            mem_wr_q    <= 1'b1;
            state_q     <= ST_WR;
          end
        end
        ST_RD: if (mem_available) begin
          mem_rd_q     <= 1'b0;
          resp_rdata_q <= load_data;
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RMW_RD: if (mem_available) begin
          // rd drops and wr rises on the same edge, so they never overlap
          mem_rd_q    <= 1'b0;
          mem_wdata_q <= merged_data;
          mem_wr_q    <= 1'b1;
          state_q     <= ST_WR;
        end
        ST_WR: begin
          mem_wr_q <= 1'b0;
          state_q  <= ST_WR_WAIT;
        end
        ST_WR_WAIT: if (mem_write_done) begin
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: if (resp_ready) begin
          resp_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized traffic against a reference model.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_write_done;
  logic        mem_available;

  logic [31:0] dut_mem [16];
  logic [31:0] ref_mem [16];
  logic        avail_gate;
  logic        rand_mode;
  int          rd_cnt, wr_cnt, both_cnt;
  logic [31:0] last_rd_addr, last_wr_addr, last_wr_data;
  int          n_vec, n_miscmp;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wr         (mem_wr),
    .mem_rd         (mem_rd),
    .mem_rdata      (mem_rdata),
    .mem_write_done (mem_write_done),
    .mem_available  (mem_available)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory stand-in: read data same cycle when gated, write ack one cycle after wr.
  assign mem_rdata     = dut_mem[mem_addr[3:0]];
  assign mem_available = mem_rd & avail_gate;

  always @(posedge clk) if (mem_wr) dut_mem[mem_addr[3:0]] <= mem_wdata;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) mem_write_done <= 1'b0;
    else        mem_write_done <= mem_wr;

  always @(negedge clk) avail_gate <= rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;

  always @(posedge clk) begin
    if (mem_rd) begin
      rd_cnt       <= rd_cnt + 1;
      last_rd_addr <= mem_addr;
    end
    if (mem_wr) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= mem_addr;
      last_wr_data <= mem_wdata;
    end
    if (mem_rd && mem_wr) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic sg);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (sg && v >= 32'h80) v = v - 32'h100;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * off[1])) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic [31:0] d);
    int          sh;
    logic [31:0] mask;
    sh   = (sz == 2'd0) ? 8 * off : 16 * off[1];
    mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int hold, input string tag);
    logic [31:0] w, exp_rd, exp_wr;
    logic        exp_err, needs_rd, got;
    int          idx, exp_lat, lat, rd0, wr0;
    idx     = int'(addr[5:2]);
    w       = ref_mem[idx];
    exp_err = 1'b0;
`ifdef MEM_ACCESS_UNIT_MISALIGN_CHECK_EN
    exp_err = (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00) || (sz == 2'd3);
`endif
    exp_wr   = 32'h0;
    needs_rd = !exp_err && (!we || sz < 2'd2);
    if (exp_err) begin
      exp_rd = 32'h0; exp_lat = 1;
    end else if (!we) begin
      exp_rd = ref_load(w, sz, addr[1:0], sg); exp_lat = 2;
    end else begin
      exp_rd  = 32'h0;
      exp_wr  = (sz >= 2'd2) ? wd : ref_merge(w, sz, addr[1:0], wd);
      exp_lat = (sz >= 2'd2) ? 3 : 4;
    end

    @(negedge clk);
    chk({tag, ":req_ready"}, 32'(req_ready), 32'd1);
    rd0        = rd_cnt;
    wr0        = wr_cnt;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    resp_ready = (hold == 0);
    @(posedge clk);
    #1 req_valid = 1'b0;

    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (resp_valid) got = 1'b1;
    end
    chk({tag, ":resp_seen"}, 32'(got), 32'd1);
    if (!rand_mode) chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ":rdata"}, resp_rdata, exp_rd);
    chk({tag, ":err"}, 32'(resp_err), 32'(exp_err));

    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_we    = ~we;
      req_addr  = $urandom;
      @(negedge clk);
      chk({tag, ":hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, ":hold_rdata"}, resp_rdata, exp_rd);
      chk({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ":resp_drop"}, 32'(resp_valid), 32'd0);
    chk({tag, ":ready_back"}, 32'(req_ready), 32'd1);

    chk({tag, ":wr_count"}, 32'(wr_cnt - wr0), 32'(we && !exp_err));
    if (!rand_mode) chk({tag, ":rd_count"}, 32'(rd_cnt - rd0), 32'(needs_rd));
    else            chk({tag, ":rd_any"}, 32'(rd_cnt != rd0), 32'(needs_rd));
    if (needs_rd) chk({tag, ":rd_addr"}, last_rd_addr, addr >> 2);
    if (we && !exp_err) begin
      chk({tag, ":wr_addr"}, last_wr_addr, addr >> 2);
      chk({tag, ":wr_data"}, last_wr_data, exp_wr);
      ref_mem[idx] = exp_wr;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0; n_miscmp = 0;
    rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
    last_rd_addr = '0; last_wr_addr = '0; last_wr_data = '0;
    rand_mode = 1'b0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    foreach (ref_mem[i]) ref_mem[i] = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst:mem_rd", 32'(mem_rd), 32'd0);
    chk("rst:mem_wr", 32'(mem_wr), 32'd0);
    chk("rst:resp_valid", 32'(resp_valid), 32'd0);
    chk("rst:resp_err", 32'(resp_err), 32'd0);
    chk("rst:mem_addr", mem_addr, 32'd0);
    chk("rst:mem_wdata", mem_wdata, 32'd0);
    chk("rst:resp_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst:req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 16; i++) do_req(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 0, "preload");

    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, "wst");
    chk("wst:mem_addr4", last_wr_addr, 32'd4);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, "wld");
    chk("wld:mem_addr4", last_rd_addr, 32'd4);

    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, 0, "pat");
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, "lb_s");
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, "lb_u");
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, "lh_s");

    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 0, "base");
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, 0, "sb");
    chk("sb:merged", last_wr_data, 32'h1122AA44);

    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 3, "stall");
    do_req(1'b0, 2'd2, 1'b0, 32'h02, 32'h0, 0, "misalign");

    // Abort a word store while it waits for the write acknowledge.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h14; req_wdata = ref_mem[5]; resp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort:wr_pulse", 32'(mem_wr), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort:mem_wr", 32'(mem_wr), 32'd0);
    chk("abort:resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort:no_resp", 32'(resp_valid), 32'd0);
    end
    chk("abort:req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 200; i++) begin
      rand_mode = (i >= 100);
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom_range(0, 2), "rnd");
    end
    rand_mode = 1'b0;
    for (int i = 0; i < 16; i++) do_req(1'b0, 2'd2, 1'b0, 32'(i * 4), 32'h0, 0, "final");
    chk("rd_wr_overlap", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front-end between the processor datapath and the word-addressed memory block.
- Accepts byte/half/word load and store requests over a valid/ready handshake, converts byte addresses to word indices and drives the memory's rd/wr/addr/data pins.
- Stores narrower than a word use read-modify-write.
- Loads are lane-aligned and sign- or zero-extended before the response is returned.

Parameters:
- ADDR_W, 32: byte-address width of requests.
- DATA_W, 32: data width; fixed at 32 and checked at elaboration.

Ports:
- clk  in  1  global clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  sign-extend loads
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  access fault (see Optional Feature)
- mem_addr  out  32  word index = {2'b00, req_addr[31:2]}
- mem_wdata  out  32  to memory data_in
- mem_wr  out  1  memory write strobe
- mem_rd  out  1  memory read strobe
- mem_rdata  in  32  from memory data_out
- mem_write_done  in  1  memory write acknowledge (one cycle after wr)
- mem_available  in  1  read data valid

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - mem_rd, mem_wr, resp_valid, resp_err = 0.
  - mem_addr, mem_wdata, resp_rdata = 0.
  - req_ready=1 once rst_n=1.
- Reset mid-operation aborts immediately: strobes drop combinationally with the state flop; a partially executed RMW store is discarded with no response.
- Request capture: on req_valid && req_ready, all request fields are registered. req_ready is 1 only in IDLE.
- FSM states: IDLE, RD, RMW_RD, WR, WR_WAIT, RESP.
- IDLE transitions:
  - load -> RD
  - word store -> WR
  - byte/half store -> RMW_RD
- RD: mem_rd=1. When mem_available=1, register the extracted lane and go to RESP; otherwise hold in RD.
  - Byte lane = addr[1:0]*8.
  - Half lane = addr[1]*16; addr[0] is ignored.
  - Word ignores addr[1:0].
  - Extension: sign if req_signed, else zero.
- RMW_RD: mem_rd=1. When mem_available=1, merge req_wdata into the addressed lane of mem_rdata, register the result as mem_wdata, go to WR.
- WR: mem_wr=1 for exactly one cycle, then WR_WAIT.
- WR_WAIT: strobes low. When mem_write_done=1, go to RESP.
- RESP: resp_valid=1; resp_rdata and resp_err stable until resp_ready=1, then IDLE. resp_valid deasserts in that cycle.
- mem_addr and mem_wdata are registered and stable for the whole access. mem_rd and mem_wr are never high together.
- Latency with zero-wait memory and resp_ready tied 1 (accept in cycle N):
  - load: resp_valid in N+2
  - word store: resp_valid in N+3
  - sub-word store: resp_valid in N+4
- Throughput: one request in flight; the next request can be accepted in the cycle after the response handshake.
- req_size=11 is treated as a word access.
- Address bits above the memory's index width wrap silently in memory.

Optional Feature:
- Macro: MEM_ACCESS_UNIT_MISALIGN_CHECK_EN.
- Defined: a request faults if any of the following holds:
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - req_size=11
  - A faulting request issues no memory strobe and goes IDLE -> RESP with resp_err=1, resp_rdata=0, responding in N+1.
- Undefined:
  - resp_err is tied 0.
  - Misaligned addresses are truncated as described in Behaviour.

Decomposition:
- Package mem_access_pkg:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD)
  - state enum
  - constant WORD_SHIFT=2
- Sub-module mem_lane_align (combinational):
  - extract+extend for loads
  - merge for stores
  - inputs: size, offset, signed, word, wdata

Test Plan:
- Reset held, then released -> all outputs 0, req_ready=1; assert rst_n low during WR_WAIT -> mem_wr=0 immediately, no resp_valid after release.
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> mem_addr=4; load resp_rdata=0xDEADBEEF at N+2; store resp at N+3.
- Byte load, signed, @0x13 of word 0x80FF7F01 -> 0xFFFFFF80; unsigned -> 0x00000080; half @0x12 signed -> 0xFFFF80FF.
- Byte store 0xAA @0x11 over word 0x11223344 -> exactly one mem_rd then one mem_wr with mem_wdata=0x1122AA44; response at N+4.
- Hold resp_ready=0 for 3 cycles -> resp_valid and resp_rdata stable, req_ready=0; a new req_valid in that window is not accepted.
- With MEM_ACCESS_UNIT_MISALIGN_CHECK_EN: word load @0x02 -> resp_err=1, resp_rdata=0 at N+1, mem_rd never asserted. Without the macro -> reads word index 0, resp_err=0.
